// File: rtl/run_length_detector.sv
// Detects runs of RUN_LEN consecutive bits equal to pattern_bit on a valid-qualified serial input.
// Optional max_run output (longest run since reset) is enabled by defining RUN_LENGTH_DETECTOR_MAX_RUN_EN.
module run_length_detector #(
    parameter int unsigned RUN_LEN = 3,
    parameter int unsigned CNT_W   = 8,
    localparam int unsigned RW     = $clog2(RUN_LEN + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             a,
    input  logic             in_valid,
    input  logic             pattern_bit,
    input  logic             overlap,
    output logic             y,
    output logic [RW-1:0]    run_len,
    output logic [CNT_W-1:0] det_cnt
`ifdef RUN_LENGTH_DETECTOR_MAX_RUN_EN
    ,
    output logic [CNT_W-1:0] max_run
`endif
);

    generate
        if (RUN_LEN < 2 || RUN_LEN > 255) begin : g_bad_run_len
            $error("run_length_detector: RUN_LEN must be in 2..255");
        end
        if (CNT_W < 1) begin : g_bad_cnt_w
            $error("run_length_detector: CNT_W must be at least 1");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        HIT
    } state_t;

    localparam logic [RW-1:0] LEN_FULL = RW'(RUN_LEN);

    state_t           state, state_n, base_state;
    logic [RW-1:0]    run_len_n, base_len;
    logic [CNT_W-1:0] det_cnt_n;
    logic             pat_q, pat_chg, match, hit, y_n;

    always_comb begin
        // A pattern change discards the run before the current bit is judged.
        pat_chg    = (pattern_bit != pat_q);
        base_len   = pat_chg ? '0 : run_len;
        base_state = pat_chg ? IDLE : state;
        match      = (a == pattern_bit);
        hit        = ({1'b0, base_len} + 1'b1) >= {1'b0, LEN_FULL};

        state_n   = base_state;
        run_len_n = base_len;
        det_cnt_n = det_cnt;
        y_n       = 1'b0;

        if (in_valid) begin
            if (!match) begin
                state_n   = IDLE;
                run_len_n = '0;
            end else if (!hit) begin
                state_n   = RUN;
                run_len_n = base_len + 1'b1;
            end else begin
                y_n = 1'b1;
                if (det_cnt != '1) begin
                    det_cnt_n = det_cnt + 1'b1;
                end
                if (overlap) begin
                    state_n   = HIT;
                    run_len_n = LEN_FULL;
                end else begin
                    state_n   = IDLE;
                    run_len_n = '0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            run_len <= '0;
            det_cnt <= '0;
            y       <= 1'b0;
            pat_q   <= pattern_bit;
        end else begin
            state   <= state_n;
            run_len <= run_len_n;
            det_cnt <= det_cnt_n;
            y       <= y_n;
            pat_q   <= pattern_bit;
        end
    end

`ifdef RUN_LENGTH_DETECTOR_MAX_RUN_EN
    logic [CNT_W-1:0] streak, streak_base, streak_n;

    // Uncapped run length: keeps counting past RUN_LEN regardless of overlap mode.
    always_comb begin
        streak_base = pat_chg ? '0 : streak;
        streak_n    = streak_base;
        if (in_valid) begin
            if (!match) begin
                streak_n = '0;
            end else if (streak_base != '1) begin
                streak_n = streak_base + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            streak  <= '0;
            max_run <= '0;
        end else begin
            streak <= streak_n;
            if (streak_n > max_run) begin
                max_run <= streak_n;
            end
        end
    end
`else
    // Without max_run the run length only needs to count up to RUN_LEN.
`endif

endmodule

// File: tb/tb_run_length_detector.sv
// Scoreboard bench for run_length_detector: three instances (RUN_LEN 3/4, CNT_W 8/2) share one stimulus stream.
module tb_run_length_detector;

    typedef struct packed {
        logic [2:0]      y;
        logic [2:0][7:0] len;
        logic [2:0][7:0] cnt;
        logic [2:0][7:0] mx;
    } rec_t;

    localparam int RL[3]   = '{3, 4, 3};
    localparam int CMAX[3] = '{255, 255, 3};

    logic clk = 1'b0;
    logic rst = 1'b1, a = 1'b0, in_valid = 1'b0, pattern_bit = 1'b1, overlap = 1'b0;
    logic       y0, y1, y2;
    logic [1:0] rl0, rl2;
    logic [2:0] rl1;
    logic [7:0] dc0, dc1;
    logic [1:0] dc2;
`ifdef RUN_LENGTH_DETECTOR_MAX_RUN_EN
    logic [7:0] mr0, mr1;
    logic [1:0] mr2;
`endif

    int   vectors = 0;
    int   errors  = 0;
    rec_t exp_q[$];

    int m_len[3];
    int m_cnt[3];
    int m_streak[3];
    int m_mx[3];
    bit m_pat = 1'b1;

    always #5 clk = ~clk;

    run_length_detector #(.RUN_LEN(3), .CNT_W(8)) u_r3 (
        .clk(clk), .rst(rst), .a(a), .in_valid(in_valid), .pattern_bit(pattern_bit),
        .overlap(overlap), .y(y0), .run_len(rl0), .det_cnt(dc0)
`ifdef RUN_LENGTH_DETECTOR_MAX_RUN_EN
        , .max_run(mr0)
`endif
    );

    run_length_detector #(.RUN_LEN(4), .CNT_W(8)) u_r4 (
        .clk(clk), .rst(rst), .a(a), .in_valid(in_valid), .pattern_bit(pattern_bit),
        .overlap(overlap), .y(y1), .run_len(rl1), .det_cnt(dc1)
`ifdef RUN_LENGTH_DETECTOR_MAX_RUN_EN
        , .max_run(mr1)
`endif
    );

    run_length_detector #(.RUN_LEN(3), .CNT_W(2)) u_c2 (
        .clk(clk), .rst(rst), .a(a), .in_valid(in_valid), .pattern_bit(pattern_bit),
        .overlap(overlap), .y(y2), .run_len(rl2), .det_cnt(dc2)
`ifdef RUN_LENGTH_DETECTOR_MAX_RUN_EN
        , .max_run(mr2)
`endif
    );

    function automatic rec_t sample();
        rec_t o;
        o        = '0;
        o.y      = {y2, y1, y0};
        o.len[0] = 8'(rl0);
        o.len[1] = 8'(rl1);
        o.len[2] = 8'(rl2);
        o.cnt[0] = dc0;
        o.cnt[1] = dc1;
        o.cnt[2] = 8'(dc2);
`ifdef RUN_LENGTH_DETECTOR_MAX_RUN_EN
        o.mx[0] = mr0;
        o.mx[1] = mr1;
        o.mx[2] = 8'(mr2);
`endif
        return o;
    endfunction

    // Applies one cycle of stimulus, predicts the post-edge outputs and queues them.
    task automatic drive(input bit r, input bit v, input bit b, input bit p, input bit ov);
        rec_t e;
        e           = '0;
        rst         = r;
        in_valid    = v;
        a           = b;
        pattern_bit = p;
        overlap     = ov;
        for (int i = 0; i < 3; i++) begin
            if (r) begin
                m_len[i]    = 0;
                m_cnt[i]    = 0;
                m_streak[i] = 0;
                m_mx[i]     = 0;
            end else begin
                if (p != m_pat) begin
                    m_len[i]    = 0;
                    m_streak[i] = 0;
                end
                if (v && b != p) begin
                    m_len[i]    = 0;
                    m_streak[i] = 0;
                end else if (v) begin
                    if (m_streak[i] < CMAX[i]) m_streak[i]++;
                    if (m_len[i] + 1 < RL[i]) begin
                        m_len[i]++;
                    end else begin
                        e.y[i] = 1'b1;
                        if (m_cnt[i] < CMAX[i]) m_cnt[i]++;
                        m_len[i] = ov ? RL[i] : 0;
                    end
                end
                if (m_streak[i] > m_mx[i]) m_mx[i] = m_streak[i];
            end
            e.len[i] = 8'(m_len[i]);
            e.cnt[i] = 8'(m_cnt[i]);
`ifdef RUN_LENGTH_DETECTOR_MAX_RUN_EN
            e.mx[i]  = 8'(m_mx[i]);
`endif
        end
        m_pat = p;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        bit   r_s[5] = '{1, 1, 0, 0, 1};
        rec_t e, o;
        for (int k = 0; k < 5; k++) begin
            drive(r_s[k], 1'b1, 1'b1, 1'b1, 1'b1);
            e = exp_q.pop_front();
            o = sample();
            vectors++;
            if (o !== e) begin
                errors++;
                $display("FAIL reset step %0d: got y=%b len=%h cnt=%h mx=%h, want y=%b len=%h cnt=%h mx=%h",
                         k, o.y, o.len, o.cnt, o.mx, e.y, e.len, e.cnt, e.mx);
            end
        end
        vectors++;
        if ({y0, rl0, dc0} !== 11'd0) begin
            errors++;
            $display("FAIL reset_midrun: got y=%b run_len=%0d det_cnt=%0d, want 0/0/0", y0, rl0, dc0);
        end
    endtask

    task automatic test_stream(input bit ov, input logic [15:0] want_mask, input logic [7:0] want_cnt);
        bit          s[13] = '{1, 0, 0, 1, 1, 1, 1, 0, 0, 1, 1, 1, 0};
        logic [15:0] ymask = '0;
        rec_t        e, o;
        for (int k = 0; k <= 13; k++) begin
            if (k == 0) drive(1'b1, 1'b0, 1'b0, 1'b1, ov);
            else        drive(1'b0, 1'b1, s[k-1], 1'b1, ov);
            e = exp_q.pop_front();
            o = sample();
            vectors++;
            if (o !== e) begin
                errors++;
                $display("FAIL stream(ov=%0d) step %0d: got y=%b len=%h cnt=%h mx=%h, want y=%b len=%h cnt=%h mx=%h",
                         ov, k, o.y, o.len, o.cnt, o.mx, e.y, e.len, e.cnt, e.mx);
            end
            if (y0) ymask[k] = 1'b1;
            if (k == 7) begin
                vectors++;
                if (rl0 !== (ov ? 2'd3 : 2'd1)) begin
                    errors++;
                    $display("FAIL stream(ov=%0d) run_len after bit 7: got %0d want %0d", ov, rl0, ov ? 3 : 1);
                end
            end
        end
        vectors++;
        if (ymask !== want_mask || dc0 !== want_cnt) begin
            errors++;
            $display("FAIL stream(ov=%0d) pulses: got mask=%h det_cnt=%0d, want mask=%h det_cnt=%0d",
                     ov, ymask, dc0, want_mask, want_cnt);
        end
    endtask

    task automatic test_zeros();
        bit          s[6] = '{0, 0, 0, 0, 0, 1};
        logic [15:0] ymask = '0;
        rec_t        e, o;
        for (int k = 0; k <= 6; k++) begin
            if (k == 0) drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
            else        drive(1'b0, 1'b1, s[k-1], 1'b0, 1'b0);
            e = exp_q.pop_front();
            o = sample();
            vectors++;
            if (o !== e) begin
                errors++;
                $display("FAIL zeros step %0d: got y=%b len=%h cnt=%h mx=%h, want y=%b len=%h cnt=%h mx=%h",
                         k, o.y, o.len, o.cnt, o.mx, e.y, e.len, e.cnt, e.mx);
            end
            if (y1) ymask[k] = 1'b1;
            if (k == 5) begin
                vectors++;
                if (rl1 !== 3'd1) begin
                    errors++;
                    $display("FAIL zeros run_len after bit 5: got %0d want 1", rl1);
                end
            end
        end
        vectors++;
        if (ymask !== 16'h0010 || dc1 !== 8'd1 || rl1 !== 3'd0) begin
            errors++;
            $display("FAIL zeros RUN_LEN=4: got mask=%h det_cnt=%0d run_len=%0d, want mask=0010 det_cnt=1 run_len=0",
                     ymask, dc1, rl1);
        end
    endtask

    task automatic test_gaps();
        bit          r_s[11] = '{1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0};
        bit          v_s[11] = '{0, 1, 0, 1, 0, 1, 0, 1, 1, 0, 1};
        logic [15:0] ymask = '0;
        rec_t        e, o;
        for (int k = 0; k < 11; k++) begin
            drive(r_s[k], v_s[k], v_s[k] ? 1'b1 : 1'($urandom_range(0, 1)), 1'b1, 1'b0);
            e = exp_q.pop_front();
            o = sample();
            vectors++;
            if (o !== e) begin
                errors++;
                $display("FAIL gaps step %0d: got y=%b len=%h cnt=%h mx=%h, want y=%b len=%h cnt=%h mx=%h",
                         k, o.y, o.len, o.cnt, o.mx, e.y, e.len, e.cnt, e.mx);
            end
            if (y0) ymask[k] = 1'b1;
        end
        vectors++;
        if (ymask !== 16'h0020 || rl0 !== 2'd1 || dc0 !== 8'd0) begin
            errors++;
            $display("FAIL gaps: got mask=%h run_len=%0d det_cnt=%0d, want mask=0020 run_len=1 det_cnt=0",
                     ymask, rl0, dc0);
        end
    endtask

    task automatic test_saturation();
        bit   p_s[12] = '{1, 1, 1, 1, 1, 1, 1, 1, 1, 0, 0, 1};
        bit   v_s[12] = '{0, 1, 1, 1, 1, 1, 1, 1, 1, 0, 1, 1};
        bit   a_s[12] = '{0, 1, 1, 1, 1, 1, 1, 1, 1, 1, 0, 1};
        rec_t e, o;
        for (int k = 0; k < 12; k++) begin
            drive(k == 0, v_s[k], a_s[k], p_s[k], 1'b1);
            e = exp_q.pop_front();
            o = sample();
            vectors++;
            if (o !== e) begin
                errors++;
                $display("FAIL saturation step %0d: got y=%b len=%h cnt=%h mx=%h, want y=%b len=%h cnt=%h mx=%h",
                         k, o.y, o.len, o.cnt, o.mx, e.y, e.len, e.cnt, e.mx);
            end
            if (k == 8) begin
                vectors++;
                if (dc0 !== 8'd6 || dc2 !== 2'd3) begin
                    errors++;
                    $display("FAIL saturation counts: got det_cnt=%0d/%0d, want 6/3", dc0, dc2);
                end
            end
            if (k >= 9) begin
                vectors++;
                if (rl0 !== (k == 9 ? 2'd0 : 2'd1)) begin
                    errors++;
                    $display("FAIL pattern_change step %0d: got run_len=%0d want %0d", k, rl0, k == 9 ? 0 : 1);
                end
            end
        end
    endtask

    task automatic test_overlap_drop();
        bit   ov_s[7] = '{1, 1, 1, 1, 1, 0, 0};
        rec_t e, o;
        for (int k = 0; k < 7; k++) begin
            drive(k == 0, k != 0, 1'b1, 1'b1, ov_s[k]);
            e = exp_q.pop_front();
            o = sample();
            vectors++;
            if (o !== e) begin
                errors++;
                $display("FAIL overlap_drop step %0d: got y=%b len=%h cnt=%h mx=%h, want y=%b len=%h cnt=%h mx=%h",
                         k, o.y, o.len, o.cnt, o.mx, e.y, e.len, e.cnt, e.mx);
            end
            if (k == 5) begin
                vectors++;
                if ({y0, rl0} !== 3'b100) begin
                    errors++;
                    $display("FAIL overlap_drop exit HIT: got y=%b run_len=%0d, want y=1 run_len=0", y0, rl0);
                end
            end
        end
    endtask

`ifdef RUN_LENGTH_DETECTOR_MAX_RUN_EN
    task automatic test_max_run();
        bit          s[10] = '{1, 1, 1, 1, 1, 1, 1, 0, 1, 1};
        logic [15:0] ymask = '0;
        rec_t        e, o;
        for (int k = 0; k <= 10; k++) begin
            if (k == 0) drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
            else        drive(1'b0, 1'b1, s[k-1], 1'b1, 1'b0);
            e = exp_q.pop_front();
            o = sample();
            vectors++;
            if (o !== e) begin
                errors++;
                $display("FAIL max_run step %0d: got y=%b len=%h cnt=%h mx=%h, want y=%b len=%h cnt=%h mx=%h",
                         k, o.y, o.len, o.cnt, o.mx, e.y, e.len, e.cnt, e.mx);
            end
            if (y0) ymask[k] = 1'b1;
        end
        vectors++;
        if (mr0 !== 8'd7 || mr2 !== 2'd3 || ymask !== 16'h0048 || dc0 !== 8'd2) begin
            errors++;
            $display("FAIL max_run: got max_run=%0d/%0d mask=%h det_cnt=%0d, want 7/3 mask=0048 det_cnt=2",
                     mr0, mr2, ymask, dc0);
        end
    endtask
`endif

    task automatic test_random();
        bit   p  = 1'b1;
        bit   ov = 1'b1;
        bit   r, v, b;
        rec_t e, o;
        for (int k = 0; k < 400; k++) begin
            if ($urandom_range(0, 31) == 0) p = ~p;
            if ($urandom_range(0, 15) == 0) ov = ~ov;
            r = (k == 0) || ($urandom_range(0, 63) == 0);
            v = ($urandom_range(0, 3) != 0);
            b = ($urandom_range(0, 7) != 0) ? p : ~p;
            drive(r, v, b, p, ov);
            e = exp_q.pop_front();
            o = sample();
            vectors++;
            if (o !== e) begin
                errors++;
                $display("FAIL random step %0d: got y=%b len=%h cnt=%h mx=%h, want y=%b len=%h cnt=%h mx=%h",
                         k, o.y, o.len, o.cnt, o.mx, e.y, e.len, e.cnt, e.mx);
            end
        end
    endtask

    initial begin
        @(posedge clk);
        #1;
        test_reset();
        test_stream(1'b1, 16'h10C0, 8'd3);
        test_stream(1'b0, 16'h1040, 8'd2);
        test_zeros();
        test_gaps();
        test_saturation();
        test_overlap_drop();
`ifdef RUN_LENGTH_DETECTOR_MAX_RUN_EN
        test_max_run();
`endif
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
